// File: rtl/reg_file_gen.sv
// Parametrised 2R/1W register file: hardwired zero, optional write bypass, post-reset clear sweep.
// Reads are combinational, writes land at the next edge; writes during the sweep are dropped and flagged.
module reg_file_gen #(
  parameter int N           = 32,
  parameter int DEPTH       = 32,
  localparam int AW         = $clog2(DEPTH),
  parameter bit ZERO_REG    = 1'b1,
  parameter bit BYPASS      = 1'b0,
  parameter int PRELOAD_IDX = 9,
  parameter     PRELOAD_VAL = 32'h00000020,
  parameter bit PRELOAD_EN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WE3,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic [AW-1:0] A3,
  input  logic [N-1:0]  WD3,
  output logic [N-1:0]  RD1,
  output logic [N-1:0]  RD2,
  output logic          ready,
  output logic          wr_drop
);

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  // An out-of-range or zero-register preload index simply never matches.
  localparam bit PRE_OK = PRELOAD_EN && (PRELOAD_IDX >= 0) && (PRELOAD_IDX < DEPTH) &&
                          !(ZERO_REG && (PRELOAD_IDX == 0));
  localparam logic [AW-1:0] PRE_IDX = AW'(PRELOAD_IDX);
  localparam logic [N-1:0]  PRE_VAL = N'(PRELOAD_VAL);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_drop_q, wr_drop_d;
  logic [N-1:0]  regs_q [DEPTH];
  logic [N-1:0]  regs_d [DEPTH];

  logic          wen;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          run_wr;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_REG && (a == '0));
  endfunction

  // A run-time write that actually lands; also the only write eligible for bypass.
  assign run_wr = (state_q == RUN) && WE3 && addr_ok(A3) && !rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    wen       = 1'b0;
    waddr     = A3;
    wdata     = WD3;
    case (state_q)
      SWEEP: begin
        wen       = !rst;
        waddr     = cnt_q;
        wdata     = (PRE_OK && (cnt_q == PRE_IDX)) ? PRE_VAL : '0;
        cnt_d     = cnt_q + 1'b1;
        wr_drop_d = WE3;
        if (cnt_q == LAST_IDX) state_d = RUN;
      end
      RUN:     wen = run_wr;
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wen) regs_d[waddr] = wdata;
  end

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if ((state_q == RUN) && addr_ok(A1)) RD1 = regs_q[A1];
    if ((state_q == RUN) && addr_ok(A2)) RD2 = regs_q[A2];
    if (BYPASS && run_wr && (A3 == A1)) RD1 = WD3;
    if (BYPASS && run_wr && (A3 == A2)) RD2 = WD3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SWEEP;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The array has no reset: the sweep is what clears it.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  assign ready   = (state_q == RUN);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_reg_file_gen.sv
// Directed bench for reg_file_gen: default, bypass and wide/shallow instances share clock and reset.
module tb_reg_file_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we3;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;
  logic        rdy_nb, rdy_bp, drop_nb, drop_bp;

  logic        we_w;
  logic [3:0]  a1_w, a2_w, a3_w;
  logic [63:0] wd_w, rd1_w, rd2_w;
  logic        rdy_w, drop_w;

  int n_vec  = 0;
  int n_miss = 0;

  reg_file_gen u_nb (
    .clk(clk), .rst(rst), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3),
    .RD1(rd1_nb), .RD2(rd2_nb), .ready(rdy_nb), .wr_drop(drop_nb)
  );

  reg_file_gen #(.BYPASS(1'b1)) u_bp (
    .clk(clk), .rst(rst), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3),
    .RD1(rd1_bp), .RD2(rd2_bp), .ready(rdy_bp), .wr_drop(drop_bp)
  );

  reg_file_gen #(.N(64), .DEPTH(16), .PRELOAD_IDX(2), .PRELOAD_VAL(64'h1_0000_0000)) u_w (
    .clk(clk), .rst(rst), .WE3(we_w), .A1(a1_w), .A2(a2_w), .A3(a3_w), .WD3(wd_w),
    .RD1(rd1_w), .RD2(rd2_w), .ready(rdy_w), .wr_drop(drop_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge with rst already low; returns with the file in RUN.
  task automatic run_sweep(input bit drops);
    for (int k = 0; k < 32; k++) begin
      we3 = drops && (k == 2 || k == 20 || k == 21);
      a3  = 5'd4;
      wd3 = 32'hFF;
      #1;
      chk("sweep_rdy",    64'(rdy_nb), 64'h0);
      chk("sweep_rdy_bp", 64'(rdy_bp), 64'h0);
      chk("sweep_rd1",    64'(rd1_nb), 64'h0);
      chk("sweep_rdy_w",  64'(rdy_w),  64'(k >= 16));
      chk("sweep_drop",   64'(drop_nb), 64'(drops && (k == 3 || k == 21 || k == 22)));
      @(negedge clk);
    end
    we3 = 1'b0;
    #1;
    chk("sweep_done_rdy",    64'(rdy_nb),  64'h1);
    chk("sweep_done_rdy_bp", 64'(rdy_bp),  64'h1);
    chk("sweep_done_drop",   64'(drop_nb), 64'h0);
  endtask

  initial begin
    rst = 1'b1; we3 = 1'b0; a1 = 5'd9; a2 = 5'd5; a3 = 5'd0; wd3 = 32'h0;
    we_w = 1'b0; a1_w = 4'd2; a2_w = 4'd9; a3_w = 4'd0; wd_w = 64'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy",   64'(rdy_nb),  64'h0);
    chk("rst_drop",  64'(drop_nb), 64'h0);
    chk("rst_rd1",   64'(rd1_nb),  64'h0);
    chk("rst_rd2",   64'(rd2_nb),  64'h0);
    chk("rst_rdy_w", 64'(rdy_w),   64'h0);
    rst = 1'b0;
    run_sweep(1'b1);

    chk("preload_rd1",    64'(rd1_nb), 64'h20);
    chk("clear_rd2",      64'(rd2_nb), 64'h0);
    chk("preload_rd1_bp", 64'(rd1_bp), 64'h20);
    chk("w_preload",      rd1_w,       64'h1_0000_0000);
    chk("w_clear",        rd2_w,       64'h0);
    a1 = 5'd4;
    #1;
    chk("dropped_reg4", 64'(rd1_nb), 64'h0);

    // Write 7, then attempt register 0.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEADBEEF;
    we_w = 1'b1; a3_w = 4'd15; wd_w = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    a3 = 5'd0; wd3 = 32'h1234; we_w = 1'b0;
    @(negedge clk);
    we3 = 1'b0; a1 = 5'd7; a2 = 5'd0; a1_w = 4'd15;
    #1;
    chk("wr_rd1",      64'(rd1_nb),  64'hDEADBEEF);
    chk("zero_rd2",    64'(rd2_nb),  64'h0);
    chk("zero_nodrop", 64'(drop_nb), 64'h0);
    chk("wr_rd1_bp",   64'(rd1_bp),  64'hDEADBEEF);
    chk("w_roundtrip", rd1_w,        64'hCAFE_F00D_1234_5678);
    a2 = 5'd7;
    #1;
    chk("same_addr_rd2", 64'(rd2_nb), 64'hDEADBEEF);

    // Same-cycle forwarding vs. next-cycle visibility.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd3; a1 = 5'd3; wd3 = 32'hA5A5A5A5; a2 = 5'd7;
    #1;
    chk("byp_same",   64'(rd1_bp), 64'hA5A5A5A5);
    chk("byp_other",  64'(rd2_bp), 64'hDEADBEEF);
    chk("nobyp_old",  64'(rd1_nb), 64'h0);
    @(negedge clk);
    we3 = 1'b0;
    #1;
    chk("nobyp_new",  64'(rd1_nb), 64'hA5A5A5A5);
    chk("byp_held",   64'(rd1_bp), 64'hA5A5A5A5);
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd0; a1 = 5'd0; wd3 = 32'hFFFF;
    #1;
    chk("byp_zero",   64'(rd1_bp), 64'h0);

    // Reset in RUN clears everything and reapplies the preload.
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd12; wd3 = 32'h55;
    @(negedge clk);
    we3 = 1'b0; a1 = 5'd12; a2 = 5'd9;
    #1;
    chk("run_wr12", 64'(rd1_nb), 64'h55);
    @(negedge clk);
    rst = 1'b1; we3 = 1'b1; a3 = 5'd12; wd3 = 32'h66;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0);
    chk("rerst_rd12",    64'(rd1_nb), 64'h0);
    chk("rerst_rd9",     64'(rd2_nb), 64'h20);
    chk("rerst_rd12_bp", 64'(rd1_bp), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
